// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REQ,
    IC_FILL
  } ic_state_e;

  localparam logic [31:0] IC_NOP = 32'h0000_0013;

  function automatic int unsigned ic_iw(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned ic_ow(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned ic_tw(input int unsigned lines, input int unsigned line_words);
    return 64 - ic_iw(lines) - ic_ow(line_words);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data storage: one asynchronous read port, one synchronous write port.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                CLK,
  input  logic                                we,
  input  logic [ic_iw(LINES)-1:0]             wr_idx,
  input  logic [ic_ow(LINE_WORDS)-3:0]        wr_word,
  input  logic [31:0]                         wr_data,
  input  logic [ic_iw(LINES)-1:0]             rd_idx,
  input  logic [ic_ow(LINE_WORDS)-3:0]        rd_word,
  output logic [31:0]                         rd_data
);

  logic [31:0] mem [LINES*LINE_WORDS];

  always_ff @(posedge CLK) begin
    if (we) mem[{wr_idx, wr_word}] <= wr_data;
  end

  assign rd_data = mem[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped blocking instruction cache with a single-line refill FSM and fence.i flush.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] PC,
  input  logic        flush,
  output logic        cache_hit,
  output logic [31:0] instruction,
  output logic        BUSY,
  output logic        MEM_REQ,
  output logic [63:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);

  localparam int unsigned IW = ic_iw(LINES);
  localparam int unsigned OW = ic_ow(LINE_WORDS);
  localparam int unsigned TW = ic_tw(LINES, LINE_WORDS);
  localparam int unsigned WW = OW - 2;

  ic_state_e        state;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q [LINES];
  logic             flush_pend;
  logic [WW-1:0]    beat;

  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic [WW-1:0] pc_word;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          beat_we;
  logic          last_beat;
  logic [31:0]   rd_data;
  logic          unused_pc_lsb;

  assign pc_idx        = PC[OW+IW-1:OW];
  assign pc_tag        = PC[63:OW+IW];
  assign pc_word       = PC[OW-1:2];
  assign unused_pc_lsb = ^PC[1:0];

  // MEM_ADDR holds the line-aligned miss address for the whole refill
  assign fill_idx  = MEM_ADDR[OW+IW-1:OW];
  assign fill_tag  = MEM_ADDR[63:OW+IW];
  assign beat_we   = (state == IC_FILL) && MEM_RVALID;
  assign last_beat = (beat == WW'(LINE_WORDS - 1));

  assign cache_hit   = (state == IC_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign instruction = cache_hit ? rd_data : IC_NOP;

  icache_data_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_ram (
    .CLK     (CLK),
    .we      (beat_we),
    .wr_idx  (fill_idx),
    .wr_word (beat),
    .wr_data (MEM_RDATA),
    .rd_idx  (pc_idx),
    .rd_word (pc_word),
    .rd_data (rd_data)
  );

  // Tag array is not reset; valid bits gate every lookup
  always_ff @(posedge CLK) begin
    if (beat_we && last_beat) tag_q[fill_idx] <= fill_tag;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IC_IDLE;
      valid_q    <= '0;
      flush_pend <= 1'b0;
      beat       <= '0;
      BUSY       <= 1'b0;
      MEM_REQ    <= 1'b0;
      MEM_ADDR   <= '0;
    end else begin
      case (state)
        IC_IDLE: begin
          if (flush) valid_q <= '0;
          if (!cache_hit) begin
            MEM_ADDR <= {PC[63:OW], OW'(0)};
            MEM_REQ  <= 1'b1;
            BUSY     <= 1'b1;
            state    <= IC_REQ;
          end
        end
        IC_REQ: begin
          if (flush) flush_pend <= 1'b1;
          if (MEM_GNT) begin
            beat    <= '0;
            MEM_REQ <= 1'b0;
            state   <= IC_FILL;
          end
        end
        IC_FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (MEM_RVALID) begin
            beat <= beat + WW'(1);
            if (last_beat) begin
              // A flush seen at any point during the refill wins over the new line
              if (flush_pend || flush) valid_q <= '0;
              else                     valid_q[fill_idx] <= 1'b1;
              flush_pend <= 1'b0;
              BUSY       <= 1'b0;
              state      <= IC_IDLE;
            end
          end
        end
        default: begin
          state <= IC_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, blocking instruction cache sitting directly upstream of the fetch stage: fetch drives `PC` and consumes `cache_hit`/`instruction` combinationally in the same cycle. On a miss it runs a refill FSM that fetches one full line over a simple request/grant/beat memory port, then resumes hitting. A `flush` input invalidates the whole cache for `fence.i`.

## Interface
- `LINES`, 64: number of lines (power of 2); index width `IW = log2(LINES)`.
- `LINE_WORDS`, 4: 32-bit words per line (power of 2); offset width `OW = log2(LINE_WORDS)+2`.
- `CLK`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PC`  in  64  fetch address; `PC[1:0]` ignored.
- `flush`  in  1  invalidate all lines (fence.i); single-cycle pulse.
- `cache_hit`  out  1  `PC` hits and FSM is IDLE (combinational).
- `instruction`  out  32  word at `PC` on hit, else `32'h00000013` (NOP).
- `BUSY`  out  1  FSM not IDLE.
- `MEM_REQ`  out  1  line refill request.
- `MEM_ADDR`  out  64  line-aligned refill address (`PC` with low `OW` bits zero).
- `MEM_GNT`  in  1  memory accepts request this cycle.
- `MEM_RVALID`  in  1  one refill beat valid.
- `MEM_RDATA`  in  32  refill beat data, ascending word order.

## Operation
- Address split: offset `PC[OW-1:0]`, word select `PC[OW-1:2]`, index `PC[OW+IW-1:OW]`, tag `PC[63:OW+IW]` (54 bits at defaults).
- Hit: `valid[idx] && tag[idx]==PC tag && state==IDLE`. Hits are never reported in REQ/FILL.
- States: IDLE, REQ, FILL.
- IDLE: on miss (not hit, not `reset`), latch `miss_addr` = line-aligned `PC`, go REQ. `MEM_RVALID` ignored in IDLE.
- REQ: `MEM_REQ`=1, `MEM_ADDR`=`miss_addr`. On `MEM_GNT`: beat counter <= 0, go FILL. `MEM_ADDR` stable until granted.
- FILL: each `MEM_RVALID` writes `MEM_RDATA` to word `beat` of line `miss_addr` index, beat++. On the beat `LINE_WORDS-1`: write tag, set valid (unless flush pending), go IDLE. Beat counter wraps to 0 there.
- `PC` changes during REQ/FILL are ignored; the fill completes, then lookup uses the current `PC` (a new miss starts a new fill).
- Flush in IDLE: all valid bits cleared at that edge; the hit computed in the flush cycle still uses pre-flush state.
- Flush in REQ/FILL: sets `flush_pend`. Fill completes with valid not set, then all valid bits cleared and `flush_pend` cleared on the final-beat edge.
- Reset: state IDLE, all valid bits 0, `flush_pend` 0, beat 0. Data/tag arrays are not reset.
- Reset mid-fill abandons the transfer; later beats are ignored because the FSM is in IDLE.

## Timing
- Outputs after reset: `cache_hit`=0, `instruction`=NOP, `BUSY`=0, `MEM_REQ`=0, `MEM_ADDR`=0.
- Hit latency: 0 cycles (combinational from `PC`).
- Miss penalty, best case: miss detected in cycle t, REQ in t+1 with `MEM_GNT`, beats in t+2..t+5, hit in t+6.
- Each grant stall cycle or beat gap adds one cycle.
- `MEM_REQ` deasserts the cycle after grant. A grant and an `RVALID` in the same REQ cycle: the beat is not accepted; memory shall not do this.
- `BUSY` = (state != IDLE), registered.

## Structure
- `icache_pkg`: state enum (`IC_IDLE`, `IC_REQ`, `IC_FILL`), `IC_NOP` = `32'h00000013`, and width functions for IW/OW/tag.
- Sub-module `icache_data_ram`: `LINES`×`LINE_WORDS`×32 storage, one async read port (index, word) and one sync write port.
- Tag/valid arrays and the FSM live in `icache_dm`.

## Test plan
- Cold miss: reset, PC=`0x1000`, grant immediately, beats `A0..A3` -> `MEM_ADDR`=`0x1000`; `cache_hit`=1 at t+6; PC=`0x1008` -> `instruction`=`A2`.
- Conflict: fill `0x1000`, then PC=`0x1400` (same index, different tag) -> miss and refill. Return to `0x1000` -> miss again.
- Flush mid-fill: `flush` during beat 1 of `0x2000` -> fill completes, then PC=`0x2000` misses and `BUSY` rises again next cycle.
- Reset mid-fill after 2 beats, then 2 stray `RVALID` beats -> no array write. PC=`0x1000` misses and `MEM_REQ`=1.
- Delayed grant: `MEM_GNT` held low 5 cycles -> `MEM_REQ`/`MEM_ADDR` stable and `cache_hit`=0 throughout; `instruction`=NOP.
- Beat gaps: `RVALID` pattern 1,0,1,0,0,1,1 -> exactly 4 words written in order; hit one cycle after the 4th beat.
